// File: rtl/spike_enc_pkg.sv
// Shared encodings for the spike encoder array: coding modes, FSM states, LFSR polynomial and seeds.
// Pure declarations, no timing or flow control of its own.
package spike_enc_pkg;

  typedef enum logic [1:0] {
    MODE_POISSON = 2'd0,
    MODE_DET     = 2'd1,
    MODE_TTFS    = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Odd multiplier makes the product a bijection, so seeds stay distinct; none hits zero for ch < 8.
  function automatic logic [15:0] lfsr_seed(input int unsigned ch);
    return 16'hACE1 ^ 16'(ch * 32'h1D35);
  endfunction

endpackage

// File: rtl/spike_channel.sv
// One encoder channel: LFSR, phase accumulator, refractory counter and TTFS flag; spike is combinational.
// Zero latency to the top's output register; state advances only on adv, no backpressure.
module spike_channel
  import spike_enc_pkg::*;
#(
  parameter int RATE_WIDTH   = 8,
  parameter int LFSR_WIDTH   = 16,
  parameter int WIN_WIDTH    = 8,
  parameter int REFRAC_WIDTH = 4,
  parameter logic [LFSR_WIDTH-1:0] SEED = LFSR_WIDTH'(1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    adv,
  input  mode_t                   mode,
  input  logic [REFRAC_WIDTH-1:0] refrac,
  input  logic [RATE_WIDTH-1:0]   rate,
  input  logic [WIN_WIDTH-1:0]    step_idx,
  output logic                    spike
);

  localparam int CW = (WIN_WIDTH > RATE_WIDTH) ? WIN_WIDTH : RATE_WIDTH;
  localparam logic [LFSR_WIDTH-1:0] POLY = LFSR_WIDTH'(LFSR_POLY);

  logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [RATE_WIDTH-1:0]   acc_q, acc_d, rate_inv;
  logic [REFRAC_WIDTH-1:0] refr_q;
  logic                    fired_q, carry, ttfs_hit, cand;

  always_comb begin
    lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    {carry, acc_d} = {1'b0, acc_q} + {1'b0, rate};
    rate_inv = ~rate;
    ttfs_hit = (CW'(step_idx) >= CW'(rate_inv)) && !fired_q;
    cand     = 1'b0;
    case (mode)
      MODE_DET:  cand = carry;
      MODE_TTFS: cand = ttfs_hit;
      default:   cand = lfsr_q[LFSR_WIDTH-1 -: RATE_WIDTH] < rate;
    endcase
    // Rate 0 is silent in every mode; TTFS would otherwise fire at the last index.
    spike = cand && (rate != '0) && (refr_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= SEED;
      acc_q   <= '0;
      refr_q  <= '0;
      fired_q <= 1'b0;
    end else if (clear) begin
      acc_q   <= '0;
      refr_q  <= '0;
      fired_q <= 1'b0;
    end else if (adv) begin
      lfsr_q <= lfsr_d;
      acc_q  <= acc_d;
      if (refr_q != '0) refr_q <= refr_q - 1'b1;
      else if (spike)   refr_q <= refrac;
      if (spike) fired_q <= 1'b1;
    end
  end

endmodule

// File: rtl/spike_encoder_array.sv
// Multi-channel rate-to-spike encoder with a fixed-length window FSM; step at t gives spikes at t+1.
// Config writes stall (cfg_ready low) while RUN; steps outside RUN are dropped, one step per cycle.
module spike_encoder_array
  import spike_enc_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int RATE_WIDTH   = 8,
  parameter int LFSR_WIDTH   = 16,
  parameter int WIN_WIDTH    = 8,
  parameter int REFRAC_WIDTH = 4,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [RATE_WIDTH-1:0]   cfg_rate,
  input  logic [1:0]              mode,
  input  logic [REFRAC_WIDTH-1:0] refrac,
  input  logic [WIN_WIDTH-1:0]    window_len,
  input  logic                    start,
  input  logic                    step,
  output logic [NUM_CH-1:0]       spikes,
  output logic                    spikes_valid,
  output logic                    busy,
  output logic                    done
);

  state_t                  state_q, state_d;
  logic [WIN_WIDTH-1:0]    step_cnt_q, win_q;
  mode_t                   mode_q;
  logic [REFRAC_WIDTH-1:0] refrac_q;
  logic                    start_acc, step_acc, cfg_we;
  logic [NUM_CH-1:0]       spike_d;

  assign cfg_ready = (state_q != ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign cfg_we    = cfg_valid && cfg_ready;

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    step_acc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (window_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (step) begin
          step_acc = 1'b1;
          if (({1'b0, step_cnt_q} + 1'b1) == {1'b0, win_q}) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_cnt_q   <= '0;
      win_q        <= '0;
      mode_q       <= MODE_POISSON;
      refrac_q     <= '0;
      spikes       <= '0;
      spikes_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      spikes_valid <= step_acc;
      if (start_acc) begin
        step_cnt_q <= '0;
        win_q      <= window_len;
        mode_q     <= mode_t'(mode);
        refrac_q   <= refrac;
      end else if (step_acc) begin
        step_cnt_q <= step_cnt_q + 1'b1;
      end
      if (step_acc) spikes <= spike_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [RATE_WIDTH-1:0] rate_q;

    // Out-of-range channel indices match no slot and are silently dropped.
    always_ff @(posedge clk) begin
      if (rst)                               rate_q <= '0;
      else if (cfg_we && cfg_ch == CH_W'(i)) rate_q <= cfg_rate;
    end

    spike_channel #(
      .RATE_WIDTH  (RATE_WIDTH),
      .LFSR_WIDTH  (LFSR_WIDTH),
      .WIN_WIDTH   (WIN_WIDTH),
      .REFRAC_WIDTH(REFRAC_WIDTH),
      .SEED        (LFSR_WIDTH'(lfsr_seed(i)))
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clear   (start_acc),
      .adv     (step_acc),
      .mode    (mode_q),
      .refrac  (refrac_q),
      .rate    (rate_q),
      .step_idx(step_cnt_q),
      .spike   (spike_d[i])
    );
  end

endmodule

// File: tb/tb_spike_encoder_array.sv
// Directed bench for spike_encoder_array: inputs driven and outputs sampled on the falling edge.
// Poisson trains are predicted from a bench-side Galois LFSR seeded from the package seed table.
module tb_spike_encoder_array;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, cfg_ready, start, step, spikes_valid, busy, done;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_rate, window_len, spikes;
  logic [1:0] mode;
  logic [3:0] refrac;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mdl [8];
  logic [63:0] col [8];
  int          cnt [8];
  int          vld_cnt, tot;
  logic [7:0]  exp_v;

  always #5 clk = ~clk;

  spike_encoder_array dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_rate(cfg_rate), .mode(mode), .refrac(refrac),
    .window_len(window_len), .start(start), .step(step), .spikes(spikes),
    .spikes_valid(spikes_valid), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input logic [7:0] r);
    cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_rate = r;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wr_all(input logic [7:0] r);
    for (int c = 0; c < 8; c++) wr(c, r);
  endtask

  task automatic go(input logic [1:0] m, input logic [3:0] rf, input logic [7:0] len);
    mode = m; refrac = rf; window_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // 64-step Poisson window at rate 128 on every channel, checked against the LFSR model.
  task automatic poisson_run(input string tag);
    for (int c = 0; c < 8; c++) mdl[c] = spike_enc_pkg::lfsr_seed(c);
    wr_all(8'd128);
    go(2'd0, 4'd0, 8'd64);
    step = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 63) step = 1'b0;
      for (int c = 0; c < 8; c++) begin
        exp_v[c] = (mdl[c][15:8] < 8'd128);
        mdl[c]   = lfsr_next(mdl[c]);
        col[c][i] = spikes[c];
      end
      chk(tag, {24'd0, spikes}, {24'd0, exp_v});
    end
    chk({tag, "_done"}, done, 1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_rate = '0; mode = '0;
    refrac = '0; window_len = '0; start = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_spikes", spikes, 0);
    chk("rst_valid", spikes_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Poisson trains straight after reset; channels must not share a sequence.
    poisson_run("poisson_a");
    for (int c = 0; c < 7; c++) chk("poisson_ch_differ", col[c] != col[c+1], 1);

    // Deterministic, ch0 rate 128: carry on odd steps.
    wr_all(8'd0);
    wr(0, 8'd128);
    go(2'd1, 4'd0, 8'd8);
    chk("det_busy", busy, 1);
    chk("det_cfg_ready", cfg_ready, 0);
    step = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) step = 1'b0;
      chk("det_valid", spikes_valid, 1);
      chk("det_spikes", spikes, (i % 2 == 1) ? 1 : 0);
      chk("det_done", done, (i == 7) ? 1 : 0);
      chk("det_busy_run", busy, (i == 7) ? 0 : 1);
    end
    @(negedge clk);
    chk("det_idle_done", done, 0);
    chk("det_idle_valid", spikes_valid, 0);
    chk("det_hold", spikes, 1);

    // Poisson, rate 0 then rate 255, 255 steps each.
    for (int pass = 0; pass < 2; pass++) begin
      wr_all(pass == 0 ? 8'd0 : 8'd255);
      go(2'd0, 4'd0, 8'd255);
      for (int c = 0; c < 8; c++) cnt[c] = 0;
      vld_cnt = 0;
      step = 1'b1;
      for (int i = 0; i < 255; i++) begin
        @(negedge clk);
        if (i == 254) step = 1'b0;
        vld_cnt += int'(spikes_valid);
        for (int c = 0; c < 8; c++) cnt[c] += int'(spikes[c]);
      end
      chk("poisson_valid_cnt", vld_cnt, 255);
      chk("poisson_done", done, 1);
      if (pass == 0) begin
        tot = 0;
        for (int c = 0; c < 8; c++) tot += cnt[c];
        chk("poisson_rate0", tot, 0);
      end else begin
        for (int c = 0; c < 8; c++) chk("poisson_rate255", (cnt[c] >= 240 && cnt[c] <= 255), 1);
      end
      @(negedge clk);
    end

    // TTFS: ch0 rate 250 fires once at index 5; ch1 rate 0 never.
    wr_all(8'd0);
    wr(0, 8'd250);
    go(2'd2, 4'd0, 8'd10);
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) step = 1'b0;
      chk("ttfs_spikes", spikes, (i == 5) ? 1 : 0);
    end
    chk("ttfs_done", done, 1);
    @(negedge clk);

    // Deterministic rate 255 with refractory 2: carry first appears at step 1.
    wr(0, 8'd255);
    go(2'd1, 4'd2, 8'd9);
    step = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 8) step = 1'b0;
      chk("refrac_spikes", spikes, (i == 1 || i == 4 || i == 7) ? 1 : 0);
    end
    @(negedge clk);

    // Step in IDLE is dropped.
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("idle_step_valid", spikes_valid, 0);
    chk("idle_step_busy", busy, 0);

    // Start with step in the same cycle; rejected write during RUN.
    mode = 2'd1; refrac = 4'd0; window_len = 8'd3; start = 1'b1; step = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ss_busy", busy, 1);
    chk("ss_valid", spikes_valid, 0);
    chk("run_cfg_ready", cfg_ready, 0);
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_rate = 8'd128;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      if (i == 2) step = 1'b0;
      chk("run_wr_spikes", spikes, (i == 0) ? 0 : 1);
    end
    chk("run_wr_done", done, 1);
    @(negedge clk);

    // Zero-length window: done next cycle, no spikes_valid.
    go(2'd1, 4'd0, 8'd0);
    chk("win0_done", done, 1);
    chk("win0_valid", spikes_valid, 0);
    chk("win0_busy", busy, 0);
    @(negedge clk);
    chk("win0_done_clr", done, 0);

    // Reset in the middle of a window.
    go(2'd1, 4'd0, 8'd10);
    step = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_spikes", spikes, 0);
    chk("midrst_valid", spikes_valid, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    rst = 1'b0; step = 1'b0;
    @(negedge clk);
    chk("midrst_no_done", done, 0);
    chk("midrst_idle", busy, 0);

    // Same Poisson run after reset reproduces the reseeded trains.
    poisson_run("poisson_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
